// File: rtl/flag_unit_if.sv
// EX/ID-side bundle for the flag unit: ALU result in, branch decision
// and statistics out.
interface flag_unit_if;
  logic        ex_valid;
  logic        ex_flush;
  logic        stall;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_alu_out;
  logic        ex_ovfl;
  logic        id_br_valid;
  logic [2:0]  id_cond;
  logic        cnt_clr;
  logic [2:0]  flags;
  logic        br_taken;
  logic [15:0] br_cnt;
  logic [15:0] br_taken_cnt;

  modport master (
    output ex_valid, ex_flush, stall, ex_alu_op,
    output ex_alu_out, ex_ovfl, id_br_valid, id_cond,
    output cnt_clr,
    input  flags, br_taken, br_cnt, br_taken_cnt
  );

  modport slave (
    input  ex_valid, ex_flush, stall, ex_alu_op,
    input  ex_alu_out, ex_ovfl, id_br_valid, id_cond,
    input  cnt_clr,
    output flags, br_taken, br_cnt, br_taken_cnt
  );
endinterface

// File: rtl/flag_unit.sv
// Z/V/N flag register with EX->ID forwarding, branch condition
// evaluation and saturating branch statistics.
module flag_unit (
  input  logic        clk,
  input  logic        rst,
  flag_unit_if.slave  bus
);
  logic [2:0]  flags_q;
  logic [2:0]  flags_next;
  logic [2:0]  cand;
  logic [2:0]  mask;
  logic        live;
  logic        z, v, n;
  logic        cond_true;
  logic [15:0] br_cnt_q;
  logic [15:0] tk_cnt_q;

  assign live = bus.ex_valid & ~bus.ex_flush;
  assign cand = {(bus.ex_alu_out == 16'h0000),
                 bus.ex_ovfl,
                 bus.ex_alu_out[15]};

  always_comb begin
    mask = 3'b000;
    unique case (1'b1)
      (bus.ex_alu_op == 4'b0000): mask = 3'b111;
      (bus.ex_alu_op == 4'b0001),
      (bus.ex_alu_op == 4'b0011),
      (bus.ex_alu_op == 4'b0100),
      (bus.ex_alu_op == 4'b0101): mask = 3'b100;
      default:                    mask = 3'b000;
    endcase
  end

  assign flags_next = live ? ((cand & mask) | (flags_q & ~mask))
                           : flags_q;
  assign {z, v, n} = flags_next;

  // Branch sees flags_next so a setter directly ahead needs no bubble
  always_comb begin
    cond_true = 1'b0;
    case (bus.id_cond)
      3'b000:  cond_true = ~z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = ~z & ~n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z | (~z & ~n);
      3'b101:  cond_true = n | z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  end

  assign bus.br_taken = bus.id_br_valid & cond_true;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (!bus.stall) begin
      flags_q <= flags_next;
    end
  end

  // Clear wins over increment and ignores stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= 16'h0000;
      tk_cnt_q <= 16'h0000;
    end else if (bus.cnt_clr) begin
      br_cnt_q <= 16'h0000;
      tk_cnt_q <= 16'h0000;
    end else if (bus.id_br_valid && !bus.stall) begin
      if (br_cnt_q != 16'hFFFF) br_cnt_q <= br_cnt_q + 16'd1;
      if (bus.br_taken && tk_cnt_q != 16'hFFFF)
        tk_cnt_q <= tk_cnt_q + 16'd1;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.br_cnt       = br_cnt_q;
  assign bus.br_taken_cnt = tk_cnt_q;
endmodule

// File: tb/tb_flag_unit.sv
// Randomized check of flag_unit against a behavioural model of the
// flag, branch and counter rules.
module tb_flag_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  flag_unit_if bus ();

  flag_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [2:0] m_flags;
  int         m_br;
  int         m_tk;

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_next();
    logic zz, vv, nn;
    zz = (bus.ex_alu_out == 16'h0000);
    vv = bus.ex_ovfl;
    nn = bus.ex_alu_out[15];
    if (!bus.ex_valid || bus.ex_flush) return m_flags;
    case (bus.ex_alu_op)
      4'd0:                return {zz, vv, nn};
      4'd1, 4'd3, 4'd4, 4'd5: return {zz, m_flags[1], m_flags[0]};
      default:             return m_flags;
    endcase
  endfunction

  function automatic logic model_cond(logic [2:0] f, logic [2:0] c);
    logic zz, vv, nn;
    {zz, vv, nn} = f;
    case (c)
      3'd0: return !zz;
      3'd1: return zz;
      3'd2: return !zz && !nn;
      3'd3: return nn;
      3'd4: return zz || (!zz && !nn);
      3'd5: return nn || zz;
      3'd6: return vv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 3'b000;
    m_br = 0;
    m_tk = 0;
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 0; bus.ex_flush = 0; bus.stall = 0;
    bus.ex_alu_op = 0; bus.ex_alu_out = 0; bus.ex_ovfl = 0;
    bus.id_br_valid = 0; bus.id_cond = 0; bus.cnt_clr = 0;
  endtask

  // Inputs are set by the caller just after a falling edge
  task automatic tick(bit do_chk);
    logic [2:0] nx;
    logic       tk;
    #1;
    nx = model_next();
    tk = bus.id_br_valid && model_cond(nx, bus.id_cond);
    if (do_chk) begin
      chk("br_taken", {15'd0, bus.br_taken}, {15'd0, tk});
      chk("flags", {13'd0, bus.flags}, {13'd0, m_flags});
      chk("br_cnt", bus.br_cnt, m_br[15:0]);
      chk("br_taken_cnt", bus.br_taken_cnt, m_tk[15:0]);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (bus.cnt_clr) begin
        m_br = 0;
        m_tk = 0;
      end else if (bus.id_br_valid && !bus.stall) begin
        if (m_br < 65535) m_br++;
        if (tk && m_tk < 65535) m_tk++;
      end
      if (!bus.stall) m_flags = nx;
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_flags", {13'd0, bus.flags}, 16'd0);
    chk("rst_br_cnt", bus.br_cnt, 16'd0);
    @(negedge clk);
    rst = 0;

    bus.id_br_valid = 1; bus.id_cond = 3'b111;
    tick(1);
    bus.id_br_valid = 0;
    #1;
    chk("first_br_cnt", bus.br_cnt, 16'd1);
    chk("first_tk_cnt", bus.br_taken_cnt, 16'd1);

    // Forwarded add result feeds EQ in the same cycle
    bus.ex_valid = 1; bus.ex_alu_op = 4'b0000;
    bus.ex_alu_out = 16'h0000; bus.ex_ovfl = 1;
    bus.id_br_valid = 1; bus.id_cond = 3'b001;
    #1;
    chk("fwd_eq", {15'd0, bus.br_taken}, 16'd1);
    tick(1);
    idle_inputs();
    #1;
    chk("add_flags", {13'd0, bus.flags}, 16'd6);

    bus.ex_valid = 1; bus.ex_alu_op = 4'b0001;
    bus.ex_alu_out = 16'h8001;
    tick(1);
    #1;
    chk("xor_flags", {13'd0, bus.flags}, 16'd2);
    bus.ex_alu_op = 4'b0111; bus.ex_alu_out = 16'h0000;
    tick(1);
    #1;
    chk("llb_flags", {13'd0, bus.flags}, 16'd2);

    bus.ex_alu_op = 4'b0000; bus.ex_alu_out = 16'hFFFE;
    bus.ex_flush = 1; bus.id_br_valid = 1; bus.id_cond = 3'b011;
    #1;
    chk("flush_lt", {15'd0, bus.br_taken}, 16'd0);
    tick(1);
    #1;
    chk("flush_flags", {13'd0, bus.flags}, 16'd2);

    bus.ex_flush = 0; bus.ex_alu_out = 16'h0000; bus.ex_ovfl = 0;
    bus.id_cond = 3'b001; bus.stall = 1;
    repeat (3) begin
      #1;
      chk("stall_eq", {15'd0, bus.br_taken}, 16'd1);
      tick(1);
    end
    chk("stall_flags", {13'd0, bus.flags}, 16'd2);
    bus.cnt_clr = 1;
    tick(1);
    bus.cnt_clr = 0;
    #1;
    chk("stall_clr", bus.br_cnt, 16'd0);
    idle_inputs();

    repeat (3000) begin
      bus.ex_valid = ($urandom_range(0, 3) != 0);
      bus.ex_flush = ($urandom_range(0, 7) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.ex_alu_op = 4'($urandom_range(0, 15));
      bus.ex_alu_out = ($urandom_range(0, 3) == 0) ? 16'h0
                       : 16'($urandom);
      bus.ex_ovfl = 1'($urandom);
      bus.id_br_valid = ($urandom_range(0, 2) != 0);
      bus.id_cond = 3'($urandom);
      bus.cnt_clr = ($urandom_range(0, 31) == 0);
      tick(1);
    end

    idle_inputs();
    bus.cnt_clr = 1;
    tick(1);
    bus.cnt_clr = 0;
    bus.id_br_valid = 1; bus.id_cond = 3'b111;
    repeat (65535) tick(0);
    #1;
    chk("sat_pre", bus.br_cnt, 16'hFFFF);
    tick(1);
    #1;
    chk("sat_br", bus.br_cnt, 16'hFFFF);
    chk("sat_tk", bus.br_taken_cnt, 16'hFFFF);

    // Async reset in the middle of a branch drops it from the counts
    bus.ex_valid = 1; bus.ex_alu_op = 4'b0000;
    bus.ex_alu_out = 16'h8000; bus.ex_ovfl = 1;
    tick(1);
    rst = 1;
    model_reset();
    tick(1);
    rst = 0;
    idle_inputs();
    #1;
    chk("rst_mid_cnt", bus.br_cnt, 16'd0);
    chk("rst_mid_flags", {13'd0, bus.flags}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
# flag_unit

Flag register and branch-condition evaluator for the 16-bit pipelined WISC-S24 core. Sits after the ALU in EX: captures Z/V/N from the ALU result and overflow per opcode class, forwards next-state flags to the branch resolver in ID, and asserts the branch-taken decision for the 3-bit condition code. Also keeps saturating branch statistics counters for the performance dump.

## Interface
- No parameters; widths fixed by the ISA (16-bit data, 4-bit ALUOp, 3-bit condition).
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a live instruction.
- ex_flush  in  1  EX instruction is being squashed; no flag commit, no forwarding.
- stall  in  1  pipeline frozen this cycle; no state update except counter clear.
- ex_alu_op  in  4  ALUOp of the EX instruction (0000 add/sub, 0001 xor, 0010 red, 0011 sll, 0100 sra, 0101 ror, 0110 paddsb, 0111 llb, 1000 lhb).
- ex_alu_out  in  16  ALU result, already saturated for add/sub.
- ex_ovfl  in  1  ALU overflow from the adder.
- id_br_valid  in  1  ID stage holds a conditional branch (B or BR).
- id_cond  in  3  branch condition code.
- cnt_clr  in  1  synchronous clear of both counters.
- flags  out  3  committed {Z, V, N}.
- br_taken  out  1  combinational branch decision for the ID branch; 0 when id_br_valid=0.
- br_cnt  out  16  branches evaluated.
- br_taken_cnt  out  16  branches taken.

## Operation
- Candidate flags: Z = (ex_alu_out == 16'h0000); N = ex_alu_out[15]; V = ex_ovfl.
- Write mask by ex_alu_op: 0000 writes Z,V,N; 0001/0011/0100/0101 write Z only; all other codes (incl. 1001–1111) write nothing. Unwritten bits hold.
- live = ex_valid & ~ex_flush.
- flags_next = live ? (masked merge of candidates over flags) : flags.
- Commit: on each edge, flags <= flags_next when ~stall.
- Forwarding: branch evaluates flags_next (not flags), so a flag-setting instruction in EX directly ahead of a branch in ID is honoured with no bubble; still applies while stall=1.
- Conditions on (Z,V,N) = flags_next: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GTE Z=1|(Z=0&N=0); 101 LTE N=1|Z=1; 110 OV V=1; 111 unconditional 1.
- br_taken = id_br_valid & cond_true.
- Counters: when id_br_valid & ~stall: br_cnt +1; if br_taken, br_taken_cnt +1. Each saturates at 16'hFFFF (holds). cnt_clr=1 zeroes both that edge, priority over increment, effective even when stall=1.

## Timing
- Reset (async, immediate): flags=3'b000, br_cnt=0, br_taken_cnt=0; br_taken follows inputs combinationally (EQ with no live EX → 0).
- flags: 1-cycle latency from EX to register; 0-cycle to br_taken via forwarding.
- br_taken purely combinational from inputs + flags; no registered path.
- Reset asserted mid-stall or mid-branch: state cleared regardless; the in-flight branch is not counted.
- ex_flush with stall: no commit, no forwarding.
- Simultaneous live EX setting Z and ID branch: decision uses new Z; committed next edge (if ~stall).

## Test plan
- Reset then id_br_valid=1, id_cond=111, no EX → br_taken=1, flags=000; after 1 edge br_cnt=1, br_taken_cnt=1.
- EX add (0000), ex_alu_out=16'h0000, ex_ovfl=1, ID cond=001 same cycle → br_taken=1 via forwarding; next cycle flags={Z,V,N}=110.
- Flags=110, EX xor out=16'h8001 → next flags=010 (Z cleared, V kept, N untouched); EX llb out=0 → flags unchanged.
- EX sub out=16'hFFFE, ex_flush=1, ID cond=011 → br_taken uses old flags (N=0 → 0); no commit.
- stall=1 for 3 cycles with live EX add out=0 and ID branch: flags and counters hold, br_taken=1 for cond 001 throughout; cnt_clr=1 during stall zeroes counters.
- Preload br_cnt to 16'hFFFF via 65535 taken branches → one more branch leaves both at 16'hFFFF.
